// File: rtl/decoder38_scan_pkg.sv
// Shared definitions for the registered 3-to-8 decoder with scan mode.
package decoder38_scan_pkg;

   localparam int NUM_LINES = 8;
   localparam int CODE_W    = 3;

   // Encoding 2'd3 is unused; the FSM falls back to IDLE if it ever appears.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STATIC = 2'd1,
      ST_SCAN   = 2'd2
   } state_t;

endpackage

// File: rtl/decoder38_scan_if.sv
// Code handshake between a code source (master) and the decoder (slave).
interface decoder38_scan_if;
   import decoder38_scan_pkg::*;

   logic              code_valid;
   logic [CODE_W-1:0] code;
   logic              code_ready;

   modport master (output code_valid, output code, input code_ready);
   modport slave  (input code_valid, input code, output code_ready);

endinterface

// File: rtl/decoder38_scan_onehot3to8.sv
// Purely combinational code-to-one-hot decoder; all lines low when disabled.
module onehot3to8
   import decoder38_scan_pkg::*;
(
   input  logic                 en,
   input  logic [CODE_W-1:0]    code,
   output logic [NUM_LINES-1:0] lines
);

   // Raise exactly one line selected by code, or none when disabled.
   always_comb begin
      lines = '0;
      if (en) lines[code] = 1'b1;
   end

endmodule

// File: rtl/decoder38_scan.sv
// Registered 3-to-8 one-hot decoder with static hold and timed up/down scan.
module decoder38_scan
   import decoder38_scan_pkg::*;
#(
   parameter int unsigned TICK_DIV = 4
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 mode,
   input  logic                 dir,
   decoder38_scan_if.slave      bus,
   output logic [NUM_LINES-1:0] dout,
   output logic                 flag,
   output logic [CODE_W-1:0]    idx
);

   // TICK_DIV=1 still gets a 1-bit counter; it sits at 0, which equals
   // CNT_MAX, so the scan steps every cycle.
   localparam int              CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

   state_t                 state, state_nxt;
   logic [CNT_W-1:0]       cnt, cnt_nxt;
   logic [CODE_W-1:0]      idx_nxt;
   logic [NUM_LINES-1:0]   dout_nxt;
   logic                   flag_nxt;
   logic                   accept;

   assign bus.code_ready = en && (state != ST_IDLE);
   assign accept         = bus.code_valid && bus.code_ready;

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state: en=0 always returns to IDLE, otherwise mode picks the state.
   always_comb begin
      state_nxt = ST_IDLE;
      case (state)
         ST_IDLE, ST_STATIC, ST_SCAN:
            if (en) state_nxt = mode ? ST_SCAN : ST_STATIC;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Next index/counter: code loads win over a timed step; mode changes clear
   // the counter without stepping.
   always_comb begin
      // NOTE: defaults first so every path assigns every output; no latches.
      idx_nxt = idx;
      cnt_nxt = '0;
      case (state)
         ST_STATIC: begin
            if (accept) idx_nxt = bus.code;
         end
         ST_SCAN: begin
            if (accept) begin
               idx_nxt = bus.code;
            end else if (state_nxt == ST_SCAN) begin
               if (cnt == CNT_MAX) begin
                  idx_nxt = dir ? idx - 1'b1 : idx + 1'b1;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         default: ;
      endcase
      flag_nxt = (state_nxt != ST_IDLE);
   end

   onehot3to8 u_onehot (
      .en    (flag_nxt),
      .code  (idx_nxt),
      .lines (dout_nxt)
   );

   // Output and counter registers, all updated on the same edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt  <= '0;
         idx  <= '0;
         dout <= '0;
         flag <= 1'b0;
      end else begin
         cnt  <= cnt_nxt;
         idx  <= idx_nxt;
         dout <= dout_nxt;
         flag <= flag_nxt;
      end
   end

endmodule

// File: tb/tb_decoder38_scan.sv
// Bench for decoder38_scan: two instances (TICK_DIV=4 and TICK_DIV=1) share
// stimulus and are compared with a per-cycle behavioural model.
module tb_decoder38_scan;

   logic       clk = 1'b0;
   logic       rst_n, en, mode, dir, code_valid;
   logic [2:0] code;
   logic [7:0] dout4, dout1;
   logic       flag4, flag1;
   logic [2:0] idx4, idx1;

   int checks = 0;
   int errors = 0;

   // Model state per instance: 0 -> TICK_DIV=4, 1 -> TICK_DIV=1.
   int td    [2] = '{4, 1};
   bit m_act [2];
   bit m_scan[2];
   int m_idx [2];
   int m_held[2];

   always #5 clk = ~clk;

   decoder38_scan_if if4 ();
   decoder38_scan_if if1 ();

   assign if4.code_valid = code_valid;
   assign if4.code       = code;
   assign if1.code_valid = code_valid;
   assign if1.code       = code;

   decoder38_scan #(.TICK_DIV(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .dir(dir),
      .bus(if4), .dout(dout4), .flag(flag4), .idx(idx4)
   );

   decoder38_scan #(.TICK_DIV(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .dir(dir),
      .bus(if1), .dout(dout1), .flag(flag1), .idx(idx1)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One cycle: apply inputs, check ready, clock, advance model, check outputs.
   task automatic cyc(input logic r, input logic e, input logic m, input logic d,
                      input logic cv, input logic [2:0] c);
      logic [7:0] exp_dout;
      rst_n = r; en = e; mode = m; dir = d; code_valid = cv; code = c;
      #1;
      chk("ready4", {7'd0, if4.code_ready}, {7'd0, e & m_act[0]});
      chk("ready1", {7'd0, if1.code_ready}, {7'd0, e & m_act[1]});
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (!r) begin
            m_act[k] = 0; m_idx[k] = 0; m_held[k] = 0;
         end else if (!e) begin
            m_act[k] = 0; m_held[k] = 0;
         end else if (!m_act[k]) begin
            m_act[k] = 1; m_scan[k] = m; m_held[k] = 0;
         end else if (m != m_scan[k]) begin
            m_scan[k] = m; m_held[k] = 0;
            if (cv) m_idx[k] = c;
         end else if (!m_scan[k]) begin
            if (cv) m_idx[k] = c;
         end else if (cv) begin
            m_idx[k] = c; m_held[k] = 0;
         end else begin
            m_held[k]++;
            if (m_held[k] == td[k]) begin
               m_held[k] = 0;
               m_idx[k]  = (m_idx[k] + (d ? 7 : 1)) % 8;
            end
         end
      end
      #1;
      exp_dout = m_act[0] ? (8'd1 << m_idx[0]) : 8'd0;
      chk("dout4", dout4, exp_dout);
      chk("flag4", {7'd0, flag4}, {7'd0, m_act[0]});
      chk("idx4",  {5'd0, idx4},  8'(m_idx[0]));
      exp_dout = m_act[1] ? (8'd1 << m_idx[1]) : 8'd0;
      chk("dout1", dout1, exp_dout);
      chk("flag1", {7'd0, flag1}, {7'd0, m_act[1]});
      chk("idx1",  {5'd0, idx1},  8'(m_idx[1]));
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; mode = 1'b0; dir = 1'b0;
      code_valid = 1'b0; code = 3'd0;

      // Reset two cycles, then enter STATIC and decode code 5.
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 1, 3);
      chk("rst_dout", dout4, 8'h00);
      chk("rst_flag", {7'd0, flag4}, 8'h00);
      cyc(1, 1, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 1, 5);
      chk("static5", dout4, 8'h20);
      for (int i = 0; i < 20; i++) cyc(1, 1, 0, 0, 0, 0);
      chk("static_hold", dout4, 8'h20);

      // Scan up from 6 with wrap; switch to SCAN while loading 6.
      cyc(1, 1, 1, 0, 1, 6);
      chk("scan_start", dout4, 8'h40);
      for (int i = 0; i < 12; i++) cyc(1, 1, 1, 0, 0, 0);
      chk("scan_wrap", dout4, 8'h02);

      // Scan down from 1 (TICK_DIV=1 instance steps every cycle).
      cyc(1, 1, 1, 1, 1, 1);
      chk("down_a", dout1, 8'h02);
      cyc(1, 1, 1, 1, 0, 0);
      chk("down_b", dout1, 8'h01);
      cyc(1, 1, 1, 1, 0, 0);
      chk("down_c", dout1, 8'h80);
      cyc(1, 1, 1, 1, 0, 0);
      chk("down_d", dout1, 8'h40);

      // Accept on the cycle where the counter would step.
      cyc(1, 1, 1, 0, 1, 0);
      for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 0, 0);
      cyc(1, 1, 1, 0, 1, 3);
      chk("accept_wins", {5'd0, idx4}, 8'd3);
      for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 0, 0);
      chk("no_early_step", {5'd0, idx4}, 8'd3);
      cyc(1, 1, 1, 0, 0, 0);
      chk("step_after4", {5'd0, idx4}, 8'd4);

      // en drop at idx 2 with a code offered; resume in STATIC.
      cyc(1, 1, 1, 0, 1, 2);
      cyc(1, 0, 1, 0, 1, 7);
      chk("en_off_dout", dout4, 8'h00);
      chk("en_off_idx", {5'd0, idx4}, 8'd2);
      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0);
      chk("resume", dout4, 8'h04);

      // Mode 1->0 at idx 4 freezes the line.
      cyc(1, 1, 1, 0, 1, 4);
      cyc(1, 1, 0, 0, 0, 0);
      chk("freeze", dout4, 8'h10);
      for (int i = 0; i < 6; i++) cyc(1, 1, 0, 0, 0, 0);
      chk("freeze_hold", dout4, 8'h10);

      // Reset mid-scan.
      cyc(1, 1, 1, 0, 1, 5);
      cyc(1, 1, 1, 0, 0, 0);
      cyc(0, 1, 1, 0, 0, 0);
      chk("midrst_idx", {5'd0, idx4}, 8'd0);
      chk("midrst_dout", dout4, 8'h00);

      // Randomised phase.
      for (int i = 0; i < 400; i++) begin
         logic r, e, m, d, cv;
         r  = ($urandom_range(39) != 0);
         e  = ($urandom_range(15) != 0);
         m  = ($urandom_range(7) == 0) ? ~mode : mode;
         d  = ($urandom_range(9) == 0) ? ~dir : dir;
         cv = ($urandom_range(5) == 0);
         cyc(r, e, m, d, cv, 3'($urandom_range(7)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/decoder38_scan.md
Name: decoder38_scan

Overview:
- Registered 3-to-8 one-hot decoder: the inverse of the board's 8-3 priority encoder path.
- Accepts a 3-bit code over a valid/ready handshake and drives 8 one-hot lines, e.g. LEDs or the line inputs of the encoder under loopback test.
- Static mode holds the decoded line.
- Scan mode walks the active line up or down from the last accepted code, one step every TICK_DIV cycles.

Parameters:
- TICK_DIV, 4: cycles each index is held in scan mode. Legal range 1..65535. 1 = step every cycle.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- en  input  1  block enable; 0 blanks the outputs
- mode  input  1  0 = static decode, 1 = auto scan
- dir  input  1  scan direction; 0 = increment, 1 = decrement
- code_valid  input  1  code offered
- code  input  3  index to decode / scan start point
- code_ready  output  1  block can accept code this cycle
- dout  output  8  one-hot decoded lines
- flag  output  1  dout is valid (one-hot)
- idx  output  3  current index

Behaviour:
- Reset (rst_n=0 sampled at posedge):
  - State IDLE, dout=8'h00, flag=0, idx=0, tick counter=0.
  - code_ready=0 while in IDLE.
  - Reset mid-scan aborts immediately; no partial step occurs.
- States are IDLE, STATIC and SCAN.
- code_ready is combinational: code_ready = en && (state != IDLE). A code is accepted on code_valid && code_ready at posedge.
- Output registers:
  - dout, flag and idx update on the same edge.
  - Invariant: flag=1 implies dout == 8'b1 << idx. flag=0 implies dout=0.
  - Latency from accept to dout is 1 cycle.
- IDLE:
  - en=1 with mode=0 goes to STATIC. en=1 with mode=1 goes to SCAN.
  - On the transition edge: flag<=1, dout<=onehot(idx), counter<=0. idx is retained, not reset.
- STATIC:
  - An accepted code sets idx<=code and dout<=onehot(code).
  - Otherwise outputs hold indefinitely.
- SCAN:
  - The counter increments each cycle.
  - When counter==TICK_DIV-1: counter<=0 and idx steps (dir=0: idx+1, dir=1: idx-1). The 3-bit idx wraps 7->0 and 0->7.
  - Each index is therefore displayed for exactly TICK_DIV cycles.
  - An accepted code sets idx<=code and counter<=0. This takes priority over a simultaneous step.
- Mode change (STATIC<->SCAN while en=1):
  - Takes effect on the next edge. idx is retained and counter<=0.
  - No glitch: dout keeps onehot(idx) across the change.
- dir change mid-scan applies at the next step; the counter is not cleared.
- en=0 from any state:
  - Next edge: state IDLE, flag<=0, dout<=0, counter<=0. idx is retained.
  - A code offered in the same cycle is not accepted, because code_ready=0.
- Counter width is max(1, clog2(TICK_DIV)). It must not overflow for TICK_DIV=1 (step every cycle).
- No X propagation: idx, dout and flag are always driven from reset values.

Decomposition:
- Shared package / header (decoder_defs):
  - NUM_LINES=8 and CODE_W=3.
  - State encodings ST_IDLE=2'd0, ST_STATIC=2'd1, ST_SCAN=2'd2. Encoding 2'd3 is illegal and recovers to IDLE.
- One natural sub-module, onehot3to8: purely combinational code-to-one-hot decoder with an enable input. It is instanced once to form the next value of dout.
- FSM, tick counter, idx register and handshake live in decoder38_scan.

Test Plan:
- Reset and static decode:
  - Stimulus: rst_n low 2 cycles, then en=1, mode=0.
  - Required: dout=00, flag=0 during reset. code_ready=1 from the cycle after STATIC is entered.
  - Offer code=5 for 1 cycle: next cycle dout=8'h20, idx=5, flag=1, held for 20 cycles with no further codes.
- Scan up with wrap (TICK_DIV=4, mode=1, dir=0, start code=6):
  - Required sequence: dout=40 for 4 cycles, then 80 x4, then 01 x4, then 02.
  - idx wraps 7->0 with no missing or doubled step.
- Scan down with TICK_DIV=1 (dir=1, start code=1):
  - Required: dout 02, 01, 80, 40 on consecutive cycles.
- Simultaneous accept and step (TICK_DIV=4):
  - Stimulus: offer code=3 exactly on the cycle where counter==3.
  - Required: idx=3 next cycle, no step applied. The next step occurs 4 cycles later.
- en drop and resume:
  - Stimulus: en=0 mid-scan at idx=2 while code_valid=1 with code=7.
  - Required: next cycle flag=0, dout=00, code_ready=0, and the code is not taken.
  - Then en=1, mode=0: dout=8'h04 (idx retained).
- Reset mid-scan and mode switch:
  - Stimulus: rst_n=0 for 1 cycle during scan.
  - Required: next cycle idx=0, dout=00, flag=0, state IDLE.
  - Separately: switching mode 1->0 at idx=4 freezes dout at 8'h10.
